// File: rtl/stage_wb.sv
// stage_wb: writeback pipeline stage. It registers the MEM-stage slot,
// extracts and extends load data, and drives the register-file write port.
// Load data is saved if the stage stalls, so a one-cycle memory Q is not lost.
module stage_wb (
  input  logic        Clock_in,
  input  logic        Reset_n_in,
  input  logic        VALID_IN,
  input  logic [31:0] PC_NEXT_INS_IN,
  input  logic [31:0] ALU_RESULT_IN,
  input  logic [31:0] MEM_DATA_IN,
  input  logic [4:0]  RD_ADDR_IN,
  input  logic        REG_WRITE_IN,
  input  logic        MEM_TO_REG_IN,
  input  logic        LINK_IN,
  input  logic [1:0]  LOAD_SIZE_IN,
  input  logic        LOAD_UNSIGNED_IN,
  input  logic        STALL_IN,
  input  logic        FLUSH_IN,
  output logic        B_R_WE,
  output logic [4:0]  B_R_WRITE_ADDR,
  output logic [31:0] B_R_WRITE_DATA,
  output logic        VALID_OUT,
  output logic        ALIGN_ERR_OUT
);

  logic        valid_q, valid_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] alu_q, alu_d;
  logic [4:0]  rd_q, rd_d;
  logic        reg_write_q, reg_write_d;
  logic        mem_to_reg_q, mem_to_reg_d;
  logic        link_q, link_d;
  logic [1:0]  load_size_q, load_size_d;
  logic        load_unsigned_q, load_unsigned_d;
  logic        hold_valid_q, hold_valid_d;
  logic [31:0] hold_q, hold_d;
  logic        align_err_q, align_err_d;

  logic [31:0] load_src;
  logic [31:0] load_ext;
  logic        misaligned;

  // Load lane selection, extension and misalignment detection.
  always_comb begin
    load_src   = hold_valid_q ? hold_q : MEM_DATA_IN;
    load_ext   = load_src;
    misaligned = 1'b0;
    unique case (load_size_q)
      2'b10: begin
        logic [7:0] b;
        b = load_src[8*alu_q[1:0] +: 8];
        load_ext = load_unsigned_q ? {24'h0, b} : {{24{b[7]}}, b};
      end
      2'b01: begin
        logic [15:0] h;
        h = alu_q[1] ? load_src[31:16] : load_src[15:0];
        load_ext   = load_unsigned_q ? {16'h0, h} : {{16{h[15]}}, h};
        misaligned = mem_to_reg_q & alu_q[0];
      end
      default: begin
        load_ext   = load_src;
        misaligned = mem_to_reg_q & (alu_q[1:0] != 2'b00);
      end
    endcase
  end

  // Register-file write port; the write lands only in the final, unstalled WB cycle.
  always_comb begin
    if (link_q)            B_R_WRITE_DATA = pc_q;
    else if (mem_to_reg_q) B_R_WRITE_DATA = load_ext;
    else                   B_R_WRITE_DATA = alu_q;
    B_R_WE         = valid_q & reg_write_q & (rd_q != 5'd0) & ~STALL_IN & ~misaligned;
    B_R_WRITE_ADDR = rd_q;
    VALID_OUT      = valid_q;
    ALIGN_ERR_OUT  = align_err_q;
  end

  // Next-state: advance, hold on stall (capturing Q once), or flush.
  always_comb begin
    valid_d         = valid_q;
    pc_d            = pc_q;
    alu_d           = alu_q;
    rd_d            = rd_q;
    reg_write_d     = reg_write_q;
    mem_to_reg_d    = mem_to_reg_q;
    link_d          = link_q;
    load_size_d     = load_size_q;
    load_unsigned_d = load_unsigned_q;
    hold_valid_d    = hold_valid_q;
    hold_d          = hold_q;
    align_err_d     = align_err_q | (valid_q & ~STALL_IN & misaligned);
    if (FLUSH_IN) begin
      valid_d      = 1'b0;
      hold_valid_d = 1'b0;
    end else if (!STALL_IN) begin
      valid_d         = VALID_IN;
      pc_d            = PC_NEXT_INS_IN;
      alu_d           = ALU_RESULT_IN;
      rd_d            = RD_ADDR_IN;
      reg_write_d     = REG_WRITE_IN;
      mem_to_reg_d    = MEM_TO_REG_IN;
      link_d          = LINK_IN;
      load_size_d     = LOAD_SIZE_IN;
      load_unsigned_d = LOAD_UNSIGNED_IN;
      hold_valid_d    = 1'b0;
    end else if (valid_q && mem_to_reg_q && !hold_valid_q) begin
      hold_valid_d = 1'b1;
      hold_d       = MEM_DATA_IN;
    end
  end

  // Stage registers with asynchronous active-low reset.
  always_ff @(posedge Clock_in or negedge Reset_n_in) begin
    if (!Reset_n_in) begin
      valid_q         <= 1'b0;
      pc_q            <= '0;
      alu_q           <= '0;
      rd_q            <= '0;
      reg_write_q     <= 1'b0;
      mem_to_reg_q    <= 1'b0;
      link_q          <= 1'b0;
      load_size_q     <= '0;
      load_unsigned_q <= 1'b0;
      hold_valid_q    <= 1'b0;
      hold_q          <= '0;
      align_err_q     <= 1'b0;
    end else begin
      valid_q         <= valid_d;
      pc_q            <= pc_d;
      alu_q           <= alu_d;
      rd_q            <= rd_d;
      reg_write_q     <= reg_write_d;
      mem_to_reg_q    <= mem_to_reg_d;
      link_q          <= link_d;
      load_size_q     <= load_size_d;
      load_unsigned_q <= load_unsigned_d;
      hold_valid_q    <= hold_valid_d;
      hold_q          <= hold_d;
      align_err_q     <= align_err_d;
    end
  end

endmodule

// File: tb/tb_stage_wb.sv
// Directed testbench for stage_wb with hand-computed expected values.
module tb_stage_wb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_in;
  logic [31:0] pc_in;
  logic [31:0] alu_in;
  logic [31:0] mem_in;
  logic [4:0]  rd_in;
  logic        rw_in, m2r_in, link_in, uns_in, stall_in, flush_in;
  logic [1:0]  size_in;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        valid_out, align_err;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  stage_wb dut (
    .Clock_in(clk), .Reset_n_in(rst_n), .VALID_IN(valid_in),
    .PC_NEXT_INS_IN(pc_in), .ALU_RESULT_IN(alu_in), .MEM_DATA_IN(mem_in),
    .RD_ADDR_IN(rd_in), .REG_WRITE_IN(rw_in), .MEM_TO_REG_IN(m2r_in),
    .LINK_IN(link_in), .LOAD_SIZE_IN(size_in), .LOAD_UNSIGNED_IN(uns_in),
    .STALL_IN(stall_in), .FLUSH_IN(flush_in),
    .B_R_WE(we), .B_R_WRITE_ADDR(waddr), .B_R_WRITE_DATA(wdata),
    .VALID_OUT(valid_out), .ALIGN_ERR_OUT(align_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one instruction on the MEM-stage inputs.
  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] alu,
                       input logic [4:0] rd, input logic rw, input logic m2r,
                       input logic lnk, input logic [1:0] sz, input logic un);
    valid_in = v; pc_in = pc; alu_in = alu; rd_in = rd; rw_in = rw;
    m2r_in = m2r; link_in = lnk; size_in = sz; uns_in = un;
  endtask

  // Capture a load, then present Q in the following cycle as a synchronous RAM would.
  task automatic issue_load(input logic [31:0] addr, input logic [4:0] rd,
                            input logic [1:0] sz, input logic un, input logic [31:0] q);
    drive(1'b1, 32'h0, addr, rd, 1'b1, 1'b1, 1'b0, sz, un);
    tick();
    drive(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
    mem_in = q;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; stall_in = 1'b0; flush_in = 1'b0; mem_in = 32'hFFFF_FFFF;
    drive(1'b1, 32'h44, 32'h55, 5'd6, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0);
    tick(); tick();
    vectors++; if (we !== 1'b0) begin miscompares++; $display("FAIL reset_we got %b exp 0", we); end
    vectors++; if (waddr !== 5'd0) begin miscompares++; $display("FAIL reset_addr got %0d exp 0", waddr); end
    vectors++; if (wdata !== 32'h0) begin miscompares++; $display("FAIL reset_data got %h exp 0", wdata); end
    vectors++; if (valid_out !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %b exp 0", valid_out); end
    vectors++; if (align_err !== 1'b0) begin miscompares++; $display("FAIL reset_align got %b exp 0", align_err); end
    drive(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_lw();
    issue_load(32'h10, 5'd5, 2'b00, 1'b0, 32'hDEAD_BEEF);
    vectors++; if (we !== 1'b1) begin miscompares++; $display("FAIL lw_we got %b exp 1", we); end
    vectors++; if (waddr !== 5'd5) begin miscompares++; $display("FAIL lw_addr got %0d exp 5", waddr); end
    vectors++; if (wdata !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL lw_data got %h exp deadbeef", wdata); end
    vectors++; if (valid_out !== 1'b1) begin miscompares++; $display("FAIL lw_valid got %b exp 1", valid_out); end
    tick();
    vectors++; if (we !== 1'b0) begin miscompares++; $display("FAIL lw_single_we got %b exp 0", we); end
  endtask

  task automatic test_lanes();
    issue_load(32'h13, 5'd4, 2'b10, 1'b0, 32'h80FF_7F01);
    vectors++; if (wdata !== 32'hFFFF_FF80) begin miscompares++; $display("FAIL lb_data got %h exp ffffff80", wdata); end
    issue_load(32'h13, 5'd4, 2'b10, 1'b1, 32'h80FF_7F01);
    vectors++; if (wdata !== 32'h0000_0080) begin miscompares++; $display("FAIL lbu_data got %h exp 00000080", wdata); end
    issue_load(32'h10, 5'd4, 2'b10, 1'b0, 32'h80FF_7F01);
    vectors++; if (wdata !== 32'h0000_0001) begin miscompares++; $display("FAIL lb0_data got %h exp 00000001", wdata); end
    issue_load(32'h11, 5'd4, 2'b10, 1'b0, 32'h80FF_7F01);
    vectors++; if (wdata !== 32'h0000_007F) begin miscompares++; $display("FAIL lb1_data got %h exp 0000007f", wdata); end
    issue_load(32'h12, 5'd4, 2'b01, 1'b0, 32'h80FF_7F01);
    vectors++; if (wdata !== 32'hFFFF_80FF) begin miscompares++; $display("FAIL lh_data got %h exp ffff80ff", wdata); end
    issue_load(32'h12, 5'd4, 2'b01, 1'b1, 32'h80FF_7F01);
    vectors++; if (wdata !== 32'h0000_80FF) begin miscompares++; $display("FAIL lhu_data got %h exp 000080ff", wdata); end
    issue_load(32'h10, 5'd4, 2'b01, 1'b0, 32'h80FF_F001);
    vectors++; if (wdata !== 32'hFFFF_F001) begin miscompares++; $display("FAIL lh0_data got %h exp fffff001", wdata); end
    issue_load(32'h14, 5'd4, 2'b11, 1'b0, 32'h1234_5678);
    vectors++; if (wdata !== 32'h1234_5678 || we !== 1'b1) begin miscompares++; $display("FAIL lsz3_data got %h/%b exp 12345678/1", wdata, we); end
    tick();
  endtask

  task automatic test_stall();
    issue_load(32'h20, 5'd7, 2'b00, 1'b0, 32'h1234_5678);
    stall_in = 1'b1;
    #1;
    vectors++; if (we !== 1'b0) begin miscompares++; $display("FAIL stall_we0 got %b exp 0", we); end
    tick();
    mem_in = 32'h0;
    #1;
    vectors++; if (we !== 1'b0) begin miscompares++; $display("FAIL stall_we1 got %b exp 0", we); end
    vectors++; if (wdata !== 32'h1234_5678) begin miscompares++; $display("FAIL stall_hold got %h exp 12345678", wdata); end
    tick();
    vectors++; if (we !== 1'b0 || valid_out !== 1'b1) begin miscompares++; $display("FAIL stall_we2 got %b/%b exp 0/1", we, valid_out); end
    tick();
    stall_in = 1'b0;
    #1;
    vectors++; if (we !== 1'b1) begin miscompares++; $display("FAIL stall_release_we got %b exp 1", we); end
    vectors++; if (wdata !== 32'h1234_5678) begin miscompares++; $display("FAIL stall_release_data got %h exp 12345678", wdata); end
    vectors++; if (waddr !== 5'd7) begin miscompares++; $display("FAIL stall_release_addr got %0d exp 7", waddr); end
    tick();
    vectors++; if (we !== 1'b0) begin miscompares++; $display("FAIL stall_after_we got %b exp 0", we); end
    // A fresh load following the stall must see live Q, not the stale held word.
    issue_load(32'h24, 5'd8, 2'b00, 1'b0, 32'hCAFE_0001);
    vectors++; if (wdata !== 32'hCAFE_0001) begin miscompares++; $display("FAIL post_stall_data got %h exp cafe0001", wdata); end
    tick();
  endtask

  task automatic test_link_rd0();
    drive(1'b1, 32'h0000_0040, 32'h9999_9999, 5'd31, 1'b1, 1'b0, 1'b1, 2'b00, 1'b0);
    tick();
    drive(1'b1, 32'h0, 32'h0000_0ABC, 5'd0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0);
    #1;
    vectors++; if (wdata !== 32'h0000_0040 || we !== 1'b1 || waddr !== 5'd31) begin miscompares++; $display("FAIL jal got %h/%b/%0d exp 00000040/1/31", wdata, we, waddr); end
    tick();
    drive(1'b1, 32'h0, 32'h0000_0123, 5'd2, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0);
    #1;
    vectors++; if (we !== 1'b0) begin miscompares++; $display("FAIL rd0_we got %b exp 0", we); end
    tick();
    drive(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
    #1;
    vectors++; if (wdata !== 32'h0000_0123 || we !== 1'b1) begin miscompares++; $display("FAIL alu got %h/%b exp 00000123/1", wdata, we); end
    tick();
  endtask

  task automatic test_misalign_flush();
    issue_load(32'h11, 5'd3, 2'b01, 1'b0, 32'h1111_2222);
    vectors++; if (we !== 1'b0) begin miscompares++; $display("FAIL mis_we got %b exp 0", we); end
    vectors++; if (align_err !== 1'b0) begin miscompares++; $display("FAIL mis_err_early got %b exp 0", align_err); end
    tick();
    vectors++; if (align_err !== 1'b1) begin miscompares++; $display("FAIL mis_err got %b exp 1", align_err); end
    issue_load(32'h10, 5'd3, 2'b00, 1'b0, 32'h5555_AAAA);
    vectors++; if (align_err !== 1'b1 || we !== 1'b1) begin miscompares++; $display("FAIL mis_sticky got %b/%b exp 1/1", align_err, we); end
    // Flush while stalled: the entry must disappear without ever writing.
    issue_load(32'h30, 5'd9, 2'b00, 1'b0, 32'h7777_7777);
    stall_in = 1'b1; flush_in = 1'b1;
    #1;
    vectors++; if (we !== 1'b0) begin miscompares++; $display("FAIL flush_we0 got %b exp 0", we); end
    tick();
    stall_in = 1'b0; flush_in = 1'b0;
    #1;
    vectors++; if (valid_out !== 1'b0 || we !== 1'b0) begin miscompares++; $display("FAIL flush got %b/%b exp 0/0", valid_out, we); end
    tick();
  endtask

  task automatic test_reset_mid_stall();
    issue_load(32'h40, 5'd10, 2'b00, 1'b0, 32'hABCD_0123);
    stall_in = 1'b1;
    tick();
    rst_n = 1'b0;
    #1;
    vectors++; if (we !== 1'b0 || valid_out !== 1'b0 || wdata !== 32'h0 || waddr !== 5'd0) begin miscompares++; $display("FAIL rst_stall got we=%b v=%b d=%h a=%0d exp 0", we, valid_out, wdata, waddr); end
    vectors++; if (align_err !== 1'b0) begin miscompares++; $display("FAIL rst_align got %b exp 0", align_err); end
    tick();
    stall_in = 1'b0;
    drive(1'b1, 32'h0, 32'h44, 5'd11, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0);
    rst_n = 1'b1;
    #1;
    vectors++; if (we !== 1'b0 || valid_out !== 1'b0) begin miscompares++; $display("FAIL rst_release got %b/%b exp 0/0", we, valid_out); end
    tick();
    drive(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
    mem_in = 32'h0BAD_F00D;
    #1;
    vectors++; if (we !== 1'b1 || waddr !== 5'd11 || wdata !== 32'h0BAD_F00D) begin miscompares++; $display("FAIL first_capture got %b/%0d/%h exp 1/11/0badf00d", we, waddr, wdata); end
    tick();
  endtask

  initial begin
    test_reset();
    test_lw();
    test_lanes();
    test_stall();
    test_link_rd0();
    test_misalign_flush();
    test_reset_mid_stall();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got running exp finished");
    $fatal(1);
  end

endmodule

// File: doc/stage_wb.md
STAGE_WB -- requirements
Module: stage_wb

Interface
REQ-001 The block SHALL have one clock and its reset SHALL be asynchronous and active-low: Clock_in in 1 (rising edge), Reset_n_in in 1 (async, active-low).
REQ-002 VALID_IN in 1: MEM-stage slot holds a real instruction.
REQ-003 PC_NEXT_INS_IN in 32: PC+4 of the instruction, the link value.
REQ-004 ALU_RESULT_IN in 32: ALU result; also the data-memory byte address.
REQ-005 MEM_DATA_IN in 32: data-memory Q, valid in the cycle after the instruction was captured (synchronous read).
REQ-006 RD_ADDR_IN in 5: destination register.
REQ-007 REG_WRITE_IN in 1, MEM_TO_REG_IN in 1, LINK_IN in 1: write enable, load select, link select.
REQ-008 LOAD_SIZE_IN in 2 (00 word, 01 half, 10 byte, 11 reserved as word), LOAD_UNSIGNED_IN in 1.
REQ-009 STALL_IN in 1: hold the stage. FLUSH_IN in 1: kill the captured entry.
REQ-010 B_R_WE out 1, B_R_WRITE_ADDR out 5, B_R_WRITE_DATA out 32: register-file write port.
REQ-011 VALID_OUT out 1, ALIGN_ERR_OUT out 1 (misaligned load, sticky until reset).

Function
REQ-012 With STALL_IN=0 and FLUSH_IN=0, each rising edge SHALL capture all *_IN control, address and PC fields into stage registers; valid_q <= VALID_IN.
REQ-013 With STALL_IN=1 and FLUSH_IN=0, all stage registers SHALL hold.
REQ-014 FLUSH_IN=1 SHALL clear valid_q and hold_valid at the edge, overriding STALL_IN.
REQ-015 Load data source: hold_valid ? hold_q : MEM_DATA_IN.
REQ-016 On an edge with STALL_IN=1, valid_q=1, MEM_TO_REG_q=1 and hold_valid=0, the block SHALL set hold_valid=1 and hold_q <= MEM_DATA_IN; it SHALL clear hold_valid on any advancing edge (REQ-012).
REQ-017 Byte lane, little-endian, from addr_q[1:0]: byte = data[8*a+7:8*a]; half = data[15:0] when a[1]=0, data[31:16] when a[1]=1; word = data.
REQ-018 Byte and half SHALL be sign-extended to 32 bits, or zero-extended when LOAD_UNSIGNED_q=1.
REQ-019 Misaligned load: half with a[0]=1, or word with a[1:0]!=00.
REQ-020 B_R_WRITE_DATA SHALL be combinational with priority LINK_q -> pc_q; else MEM_TO_REG_q -> extended load data; else alu_q.
REQ-021 B_R_WE = valid_q & REG_WRITE_q & (rd_q!=0) & ~STALL_IN & ~misaligned, so each instruction writes exactly once, in its final WB cycle.
REQ-022 B_R_WRITE_ADDR = rd_q; VALID_OUT = valid_q.
REQ-023 ALIGN_ERR_OUT SHALL set on the edge ending the final WB cycle of a valid misaligned load (valid_q=1, STALL_IN=0).
REQ-024 Latency: an instruction captured at edge N SHALL write during cycle N..N+1, i.e. one cycle plus any stall cycles.

Reset
REQ-025 Reset_n_in=0 SHALL asynchronously clear valid_q, hold_valid, hold_q, all stage registers and ALIGN_ERR_OUT; B_R_WE, B_R_WRITE_ADDR, B_R_WRITE_DATA and VALID_OUT SHALL read 0.
REQ-026 Reset asserted mid-stall SHALL discard the held entry with no write after release; the first capture SHALL occur on the first rising edge after release.

Verification
REQ-027 lw, addr 0x10, rd=5, Q=0xDEADBEEF -> one cycle later B_R_WE=1, ADDR=5, DATA=0xDEADBEEF.
REQ-028 lb, addr 0x13, Q=0x80FF7F01 -> DATA=0xFFFFFF80; lbu -> 0x00000080; lh, addr 0x12 -> 0xFFFF80FF.
REQ-029 lw, STALL_IN high 3 cycles, Q changes to 0x0 after the first stall edge -> B_R_WE low while stalled, single write of the original value after release.
REQ-030 jal, LINK_IN=1, PC_NEXT=0x0040, rd=31 -> DATA=0x00000040; rd=0 with REG_WRITE=1 -> B_R_WE stays 0.
REQ-031 lh, addr 0x11 -> B_R_WE=0, ALIGN_ERR_OUT=1 thereafter; FLUSH_IN with STALL_IN -> VALID_OUT=0, no write.
REQ-032 Reset_n_in low during a stalled load -> outputs 0 immediately, no write after release.
